seg_scan_receiver: RTL and testbench
====================================

Name: seg_scan_receiver

Overview:
- Receiving end of the multiplexed 8-digit 7-segment scan interface that the stopwatch drives (one-hot-low anode plus active-low segments).
- Samples the anode/segment pair, filters transients, and decodes each segment pattern back to a 4-bit digit value.
- Assembles digits in scan order into a complete 8-digit frame and flags sequencing, pattern and timeout errors.
- Used as an on-chip display readback/monitor and as a self-checking element in system benches.

Parameters:
- STABLE_CNT, 4, consecutive clocks an anode/segment pair must stay unchanged before it is captured (range 1..65535).
- TIMEOUT_CNT, 200000, clocks allowed between two captures before the frame is declared stale (range 2..2^24-1).

Ports:
- clkIn  input  1  system clock
- rstIn  input  1  reset; one clock; reset is synchronous and active-high
- anIn  input  8  anodes, active-low one-hot; bit7 = leftmost digit
- segIn  input  7  segments, active-low, {g,f,e,d,c,b,a}
- digitsOut  output  32  frame; [31:28] = digit7 (leftmost) ... [3:0] = digit0
- blankOut  output  8  per-digit flag: pattern 7'h7F (blank) was captured
- frameValidOut  output  1  one-clock pulse when digitsOut/blankOut update
- seqErrOut  output  1  one-clock pulse on an out-of-order digit position
- segErrOut  output  1  one-clock pulse on an undecodable pattern
- staleOut  output  1  level; high after a timeout, cleared by the next frameValidOut

Behaviour:
- Reset (synchronous): digitsOut = 0, blankOut = 8'hFF, all pulses = 0, staleOut = 0, FSM = IDLE, counters = 0, sample register = {8'hFF, 7'h7F}.
- Input stage: {anIn, segIn} is registered every clock.
  - stableCnt resets to 0 whenever the registered value differs from its previous value; otherwise it increments, saturating.
  - A "dwell" is one run of an unchanged value.
- Capture: occurs once per dwell, on the clock where stableCnt reaches STABLE_CNT-1, and only if anodes are exactly one-hot-low.
  - Any other anode value (e.g. 8'hFF, two digits low) is idle and never captured.
  - Total latency is STABLE_CNT+1 clocks from the input change to capture.
- Decode table (pattern -> digit):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9.
  - 7F -> blank: digit 4'h0, blank flag set.
  - Any other pattern -> segErrOut pulse, frame aborted, FSM -> IDLE.
- Frame FSM:
  - IDLE: waits for a capture at position 7. Captures at other positions are ignored with no error. A position-7 capture -> COLLECT, expected position = 6.
  - COLLECT: a capture at the expected position stores it into the shadow frame and decrements the expected position.
  - COLLECT, position-0 capture: shadow frame copied to digitsOut/blankOut, frameValidOut pulsed the next clock, staleOut cleared, expected position = 7 (stays in COLLECT, so back-to-back frames are accepted).
  - COLLECT, capture at a wrong position: seqErrOut pulse. If that position is 7, a new frame starts (expected = 6); otherwise -> IDLE.
- Timeout: timeoutCnt clears on every capture and increments otherwise.
  - On reaching TIMEOUT_CNT: staleOut = 1, FSM -> IDLE, shadow frame discarded.
  - digitsOut keeps the last good frame.
- Simultaneous events: segErr takes priority over seqErr, and at most one error pulse is issued per capture. A timeout on the same clock as a capture is ignored (the capture wins).
- rstIn mid-frame: partial frame discarded, all outputs return to their reset values the next clock.

Optional Feature:
- SEG_RX_HEX_EN: when defined, the decode table also accepts hex patterns 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F, with no segErr for these.
- When undefined, those patterns raise segErrOut.

Decomposition:
- Shared package (stopwatch_pkg) holds:
  - the segment-code constants for 0-9, A-F and blank;
  - the scan anode constants 8'h7F..8'hFE;
  - the FSM state encoding.
- One natural sub-module, seg_pattern_decoder: combinational pattern -> {valid, blank, digit[3:0]}, shared with the optional hex mode.
- The stability filter, FSM and timeout stay in the top module.

Test Plan:
- STABLE_CNT=4; scan 12:34:56.78 (digit7..0 = 1,2,3,4,5,6,7,8), 10 clocks per digit -> one frameValidOut, digitsOut = 32'h1234_5678, blankOut = 8'h00.
- Same scan, but digit 5 holds each value for only 3 clocks (glitch) -> no capture for position 5; the position-4 capture gives seqErrOut and no frame; the next full scan gives a frame.
- Scan order 7,6,4 -> seqErrOut pulse on position 4, FSM IDLE; a restart at position 7 with a full scan -> frame 32'h0000_0000 when all patterns are 7'h40.
- Digit 3 pattern 7'h08 -> segErrOut without SEG_RX_HEX_EN. With the macro defined -> digitsOut[15:12] = 4'hA.
- TIMEOUT_CNT=50; stop the scan after position 6 -> staleOut high at clock 50 after the last capture, and digitsOut holds the previous frame; a full scan clears staleOut.
- rstIn asserted mid-frame (after position 4) -> next clock all outputs are at reset values; a fresh full scan produces exactly one frame.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch 7-segment scan interface: segment codes,
// scan anode codes and the receiver frame FSM encoding.
package stopwatch_pkg;

  // Active-low segment codes, {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low one-hot scan anodes, position 7 is the leftmost digit
  localparam logic [7:0] AN_POS7 = 8'h7F;
  localparam logic [7:0] AN_POS6 = 8'hBF;
  localparam logic [7:0] AN_POS5 = 8'hDF;
  localparam logic [7:0] AN_POS4 = 8'hEF;
  localparam logic [7:0] AN_POS3 = 8'hF7;
  localparam logic [7:0] AN_POS2 = 8'hFB;
  localparam logic [7:0] AN_POS1 = 8'hFD;
  localparam logic [7:0] AN_POS0 = 8'hFE;
  localparam logic [7:0] AN_IDLE = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } state_t;

endpackage

// File: rtl/seg_pattern_decoder.sv
// Combinational segment pattern -> {valid, blank, digit}; hex letters A-F are
// accepted only when SEG_RX_HEX_EN is defined.
module seg_pattern_decoder
  import stopwatch_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic       blank,
  output logic [3:0] digit
);

  always_comb begin
    valid = 1'b1;
    blank = 1'b0;
    digit = 4'h0;
    case (seg)
      SEG_0:     digit = 4'h0;
      SEG_1:     digit = 4'h1;
      SEG_2:     digit = 4'h2;
      SEG_3:     digit = 4'h3;
      SEG_4:     digit = 4'h4;
      SEG_5:     digit = 4'h5;
      SEG_6:     digit = 4'h6;
      SEG_7:     digit = 4'h7;
      SEG_8:     digit = 4'h8;
      SEG_9:     digit = 4'h9;
      SEG_BLANK: blank = 1'b1;
`ifdef SEG_RX_HEX_EN
      SEG_A:     digit = 4'hA;
      SEG_B:     digit = 4'hB;
      SEG_C:     digit = 4'hC;
      SEG_D:     digit = 4'hD;
      SEG_E:     digit = 4'hE;
      SEG_F:     digit = 4'hF;
`endif
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_receiver.sv
// Receives the multiplexed 8-digit 7-segment scan, filters transients and rebuilds
// the 8-digit frame with sequence/pattern/timeout flags. Optional macro: SEG_RX_HEX_EN.
module seg_scan_receiver
  import stopwatch_pkg::*;
#(
  parameter int STABLE_CNT  = 4,
  parameter int TIMEOUT_CNT = 200000
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic [7:0]  anIn,
  input  logic [6:0]  segIn,
  output logic [31:0] digitsOut,
  output logic [7:0]  blankOut,
  output logic        frameValidOut,
  output logic        seqErrOut,
  output logic        segErrOut,
  output logic        staleOut
);

  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CNT - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CNT - 1);

  logic [7:0]  an_q;
  logic [6:0]  seg_q;
  logic [15:0] stable_cnt;
  logic [23:0] timeout_cnt;
  state_t      state, state_nxt;
  logic [2:0]  exp_pos, exp_nxt;
  logic [2:0]  pos;
  logic        one_hot, capture, timeout;
  logic        store, frame_done, seq_err_nxt, seg_err_nxt;
  logic        dec_valid, dec_blank;
  logic [3:0]  dec_digit;
  // Position 0 never lands in the shadow: it goes straight to the output frame.
  logic [31:4] shadow_dig;
  logic [7:1]  shadow_blk;

  seg_pattern_decoder u_dec (
    .seg   (seg_q),
    .valid (dec_valid),
    .blank (dec_blank),
    .digit (dec_digit)
  );

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      an_q       <= AN_IDLE;
      seg_q      <= SEG_BLANK;
      stable_cnt <= '0;
    end else begin
      an_q  <= anIn;
      seg_q <= segIn;
      if ({anIn, segIn} != {an_q, seg_q}) stable_cnt <= '0;
      else if (stable_cnt != 16'hFFFF)    stable_cnt <= stable_cnt + 16'd1;
    end
  end

  always_comb begin
    one_hot = 1'b1;
    pos     = 3'd0;
    case (an_q)
      AN_POS7: pos = 3'd7;
      AN_POS6: pos = 3'd6;
      AN_POS5: pos = 3'd5;
      AN_POS4: pos = 3'd4;
      AN_POS3: pos = 3'd3;
      AN_POS2: pos = 3'd2;
      AN_POS1: pos = 3'd1;
      AN_POS0: pos = 3'd0;
      default: one_hot = 1'b0;
    endcase
  end

  // The counter passes STABLE_LAST exactly once per dwell, so this is one capture per dwell.
  assign capture = one_hot && (stable_cnt == STABLE_LAST);
  assign timeout = !capture && (timeout_cnt == TIMEOUT_LAST);

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state   <= ST_IDLE;
      exp_pos <= 3'd7;
    end else begin
      state   <= state_nxt;
      exp_pos <= exp_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    exp_nxt     = exp_pos;
    store       = 1'b0;
    frame_done  = 1'b0;
    seq_err_nxt = 1'b0;
    seg_err_nxt = 1'b0;
    if (capture) begin
      if (!dec_valid) begin
        seg_err_nxt = 1'b1;
        state_nxt   = ST_IDLE;
      end else if (state == ST_IDLE) begin
        if (pos == 3'd7) begin
          store     = 1'b1;
          state_nxt = ST_COLLECT;
          exp_nxt   = 3'd6;
        end
      end else if (pos == exp_pos) begin
        store = 1'b1;
        if (pos == 3'd0) begin
          frame_done = 1'b1;
          exp_nxt    = 3'd7;
        end else begin
          exp_nxt = exp_pos - 3'd1;
        end
      end else begin
        seq_err_nxt = 1'b1;
        if (pos == 3'd7) begin
          store   = 1'b1;
          exp_nxt = 3'd6;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    end else if (timeout) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      timeout_cnt   <= '0;
      shadow_dig    <= '0;
      shadow_blk    <= '1;
      digitsOut     <= '0;
      blankOut      <= 8'hFF;
      frameValidOut <= 1'b0;
      seqErrOut     <= 1'b0;
      segErrOut     <= 1'b0;
      staleOut      <= 1'b0;
    end else begin
      frameValidOut <= frame_done;
      seqErrOut     <= seq_err_nxt;
      segErrOut     <= seg_err_nxt;
      if (capture)                          timeout_cnt <= '0;
      else if (timeout_cnt != TIMEOUT_LAST) timeout_cnt <= timeout_cnt + 24'd1;
      if (store && pos != 3'd0) begin
        shadow_dig[{pos, 2'b00} +: 4] <= dec_digit;
        shadow_blk[pos]               <= dec_blank;
      end
      if (frame_done) begin
        digitsOut <= {shadow_dig, dec_digit};
        blankOut  <= {shadow_blk, dec_blank};
        staleOut  <= 1'b0;
      end else if (timeout) begin
        staleOut <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_receiver.sv
// Self-checking bench for seg_scan_receiver: directed scan scenarios plus a
// randomized scan compared against a frame-level reference model.
module tb_seg_scan_receiver;

  localparam int STABLE = 4;
  localparam int TMO    = 50;
`ifdef SEG_RX_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif
  localparam logic [7:0] IDLE_AN = 8'hFF;
  localparam logic [6:0] BLANK   = 7'h7F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  an  = 8'hFF;
  logic [6:0]  seg = 7'h7F;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic        fv, seqe, sege, stale;

  int total = 0;
  int bad   = 0;

  seg_scan_receiver #(.STABLE_CNT(STABLE), .TIMEOUT_CNT(TMO)) dut (
    .clkIn         (clk),
    .rstIn         (rst),
    .anIn          (an),
    .segIn         (seg),
    .digitsOut     (digits),
    .blankOut      (blank),
    .frameValidOut (fv),
    .seqErrOut     (seqe),
    .segErrOut     (sege),
    .staleOut      (stale)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Output monitor
  int          n_frames = 0, n_seq = 0, n_seg = 0;
  logic [31:0] obs_dig[$];
  logic [7:0]  obs_blk[$];
  always @(negedge clk) begin
    if (fv) begin
      n_frames++;
      obs_dig.push_back(digits);
      obs_blk.push_back(blank);
    end
    if (seqe) n_seq++;
    if (sege) n_seg++;
  end

  // Reference model: list of dwells long enough to be captured
  int          cap_pos[$];
  logic [6:0]  cap_pat[$];
  logic [31:0] exp_dig[$];
  logic [7:0]  exp_blk[$];
  int          exp_seq, exp_seg;

  function automatic int pos_of(input logic [7:0] a);
    pos_of = -1;
    for (int i = 0; i < 8; i++) if (!a[i]) pos_of = i;
  endfunction

  function automatic logic [7:0] an_of(input int p);
    an_of = ~(8'b1 << p);
  endfunction

  function automatic bit dec(input logic [6:0] p, output logic [3:0] d, output bit b);
    d = 4'h0;
    b = 1'b0;
    if (p == BLANK) begin
      b = 1'b1;
      return 1'b1;
    end
    for (int i = 0; i < 16; i++)
      if (seg_tab[i] == p && (i < 10 || HEX_EN)) begin
        d = 4'(i);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic void model_eval();
    int          nxt = -1;
    logic [31:0] bd = '0;
    logic [7:0]  bb = '0;
    logic [3:0]  d;
    bit          b;
    exp_dig.delete();
    exp_blk.delete();
    exp_seq = 0;
    exp_seg = 0;
    foreach (cap_pos[k]) begin
      int p;
      p = cap_pos[k];
      if (!dec(cap_pat[k], d, b)) begin
        exp_seg++;
        nxt = -1;
      end else if (nxt < 0 && p != 7) begin
        nxt = -1;
      end else if (nxt < 0 || p == nxt || p == 7) begin
        if (nxt >= 0 && p != nxt) exp_seq++;
        bd[p*4 +: 4] = d;
        bb[p]        = b;
        if (p == 0) begin
          exp_dig.push_back(bd);
          exp_blk.push_back(bb);
          nxt = 7;
        end else begin
          nxt = p - 1;
        end
      end else begin
        exp_seq++;
        nxt = -1;
      end
    end
  endfunction

  task automatic step(input logic [7:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    if (n >= STABLE && $countones(~a) == 1) begin
      cap_pos.push_back(pos_of(a));
      cap_pat.push_back(s);
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scan positions 7 down to last_pos; short_pos holds only 3 clocks.
  task automatic scan(input logic [31:0] d, input logic [7:0] bl, input int short_pos, input int last_pos);
    for (int p = 7; p >= last_pos; p--)
      step(an_of(p), bl[p] ? BLANK : seg_tab[d[p*4 +: 4]], (p == short_pos) ? 3 : 10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (digits !== 32'h0)  begin bad++; $display("FAIL reset_digits got=%h want=%h", digits, 32'h0); end
    total++;
    if (blank !== 8'hFF)   begin bad++; $display("FAIL reset_blank got=%h want=ff", blank); end
    total++;
    if ({fv, seqe, sege} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {fv, seqe, sege}); end
    total++;
    if (stale !== 1'b0)    begin bad++; $display("FAIL reset_stale got=%b want=0", stale); end
    total++;
    rst = 1'b0;
  endtask

  task automatic test_basic_scan();
    int f0, s0, g0;
    step(IDLE_AN, BLANK, 60);
    if (stale !== 1'b1) begin bad++; $display("FAIL idle_stale got=%b want=1", stale); end
    total++;
    f0 = n_frames; s0 = n_seq; g0 = n_seg;
    scan(32'h1234_5678, 8'h00, -1, 0);
    step(IDLE_AN, BLANK, 6);
    if (n_frames - f0 !== 1) begin bad++; $display("FAIL basic_frames got=%0d want=1", n_frames - f0); end
    total++;
    if (digits !== 32'h1234_5678) begin bad++; $display("FAIL basic_digits got=%h want=12345678", digits); end
    total++;
    if (blank !== 8'h00) begin bad++; $display("FAIL basic_blank got=%h want=00", blank); end
    total++;
    if (n_seq - s0 + n_seg - g0 !== 0) begin bad++; $display("FAIL basic_errs got=%0d want=0", n_seq - s0 + n_seg - g0); end
    total++;
    if (stale !== 1'b0) begin bad++; $display("FAIL basic_stale_clear got=%b want=0", stale); end
    total++;
  endtask

  task automatic test_glitch();
    int f0, s0;
    step(IDLE_AN, BLANK, 60);
    f0 = n_frames; s0 = n_seq;
    scan(32'h1234_5678, 8'h00, 5, 0);
    step(IDLE_AN, BLANK, 6);
    if (n_frames - f0 !== 0) begin bad++; $display("FAIL glitch_frames got=%0d want=0", n_frames - f0); end
    total++;
    if (n_seq - s0 !== 1) begin bad++; $display("FAIL glitch_seqerr got=%0d want=1", n_seq - s0); end
    total++;
    scan(32'h8765_4321, 8'h00, -1, 0);
    step(IDLE_AN, BLANK, 6);
    if (n_frames - f0 !== 1) begin bad++; $display("FAIL glitch_recover_frames got=%0d want=1", n_frames - f0); end
    total++;
    if (digits !== 32'h8765_4321) begin bad++; $display("FAIL glitch_recover_digits got=%h want=87654321", digits); end
    total++;
  endtask

  task automatic test_seq_order();
    int f0, s0;
    step(IDLE_AN, BLANK, 60);
    f0 = n_frames; s0 = n_seq;
    step(an_of(7), 7'h40, 10);
    step(an_of(6), 7'h40, 10);
    step(an_of(4), 7'h40, 10);
    step(IDLE_AN, BLANK, 4);
    if (n_seq - s0 !== 1) begin bad++; $display("FAIL order_seqerr got=%0d want=1", n_seq - s0); end
    total++;
    scan(32'h0, 8'h00, -1, 0);
    step(IDLE_AN, BLANK, 6);
    if (n_frames - f0 !== 1) begin bad++; $display("FAIL order_frames got=%0d want=1", n_frames - f0); end
    total++;
    if (digits !== 32'h0) begin bad++; $display("FAIL order_digits got=%h want=00000000", digits); end
    total++;
  endtask

  task automatic test_seg_err();
    int f0, g0, want_f, want_g;
    logic [3:0] want_d3;
`ifdef SEG_RX_HEX_EN
    want_f = 1; want_g = 0; want_d3 = 4'hA;
`else
    want_f = 0; want_g = 1; want_d3 = 4'h0;
`endif
    step(IDLE_AN, BLANK, 60);
    f0 = n_frames; g0 = n_seg;
    scan(32'h1234_A678, 8'h00, -1, 0);
    step(IDLE_AN, BLANK, 6);
    if (n_seg - g0 !== want_g) begin bad++; $display("FAIL segerr_count got=%0d want=%0d", n_seg - g0, want_g); end
    total++;
    if (n_frames - f0 !== want_f) begin bad++; $display("FAIL segerr_frames got=%0d want=%0d", n_frames - f0, want_f); end
    total++;
    if (digits[15:12] !== want_d3) begin bad++; $display("FAIL segerr_digit3 got=%h want=%h", digits[15:12], want_d3); end
    total++;
  endtask

  task automatic test_timeout();
    step(IDLE_AN, BLANK, 60);
    scan(32'h9081_7203, 8'h02, -1, 0);
    scan(32'h5555_5555, 8'h00, -1, 6);
    // last capture lands 5 clocks into the position-6 dwell
    step(IDLE_AN, BLANK, 44);
    if (stale !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b want=0", stale); end
    total++;
    step(IDLE_AN, BLANK, 1);
    if (stale !== 1'b1) begin bad++; $display("FAIL timeout_stale got=%b want=1", stale); end
    total++;
    if (digits !== 32'h9081_7203) begin bad++; $display("FAIL timeout_hold got=%h want=90817203", digits); end
    total++;
    if (blank !== 8'h02) begin bad++; $display("FAIL timeout_hold_blank got=%h want=02", blank); end
    total++;
    scan(32'h2468_1357, 8'h00, -1, 0);
    step(IDLE_AN, BLANK, 6);
    if (stale !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b want=0", stale); end
    total++;
    if (digits !== 32'h2468_1357) begin bad++; $display("FAIL timeout_newframe got=%h want=24681357", digits); end
    total++;
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    step(IDLE_AN, BLANK, 60);
    scan(32'h1111_2222, 8'h00, -1, 4);
    if (stale !== 1'b1) begin bad++; $display("FAIL midrst_pre_stale got=%b want=1", stale); end
    total++;
    rst = 1'b1;
    step(IDLE_AN, BLANK, 1);
    rst = 1'b0;
    if ({digits, blank} !== {32'h0, 8'hFF}) begin bad++; $display("FAIL midrst_frame got=%h/%h want=00000000/ff", digits, blank); end
    total++;
    if ({fv, seqe, sege, stale} !== 4'b0000) begin bad++; $display("FAIL midrst_flags got=%b want=0000", {fv, seqe, sege, stale}); end
    total++;
    f0 = n_frames;
    scan(32'h3141_5926, 8'h00, -1, 0);
    step(IDLE_AN, BLANK, 6);
    if (n_frames - f0 !== 1) begin bad++; $display("FAIL midrst_frames got=%0d want=1", n_frames - f0); end
    total++;
    if (digits !== 32'h3141_5926) begin bad++; $display("FAIL midrst_digits got=%h want=31415926", digits); end
    total++;
  endtask

  task automatic test_random();
    int f0, q0, s0, g0, prev, pp, r, dw;
    bit prev_short;
    logic [6:0] pat;
    step(IDLE_AN, BLANK, 60);
    cap_pos.delete();
    cap_pat.delete();
    f0 = n_frames; q0 = obs_dig.size(); s0 = n_seq; g0 = n_seg;
    prev = 0;
    prev_short = 1'b0;
    for (int i = 0; i < 80; i++) begin
      pp = (prev == 0) ? 7 : prev - 1;
      if ($urandom_range(0, 9) == 0) begin
        pp = $urandom_range(0, 7);
        if (pp == prev) pp = (pp + 1) % 8;
      end
      r = $urandom_range(0, 19);
      if (r < 10)      pat = seg_tab[r];
      else if (r < 12) pat = BLANK;
      else if (r < 14) pat = seg_tab[10 + $urandom_range(0, 5)];
      else if (r < 15) pat = 7'h55;
      else             pat = seg_tab[r - 15];
      if (!prev_short && $urandom_range(0, 5) == 0) begin
        dw = $urandom_range(1, 3);
        prev_short = 1'b1;
      end else begin
        dw = $urandom_range(4, 12);
        prev_short = 1'b0;
      end
      step(an_of(pp), pat, dw);
      prev = pp;
    end
    step(IDLE_AN, BLANK, 8);
    model_eval();
    if (n_frames - f0 !== exp_dig.size()) begin bad++; $display("FAIL rand_frames got=%0d want=%0d", n_frames - f0, exp_dig.size()); end
    total++;
    if (n_seq - s0 !== exp_seq) begin bad++; $display("FAIL rand_seqerr got=%0d want=%0d", n_seq - s0, exp_seq); end
    total++;
    if (n_seg - g0 !== exp_seg) begin bad++; $display("FAIL rand_segerr got=%0d want=%0d", n_seg - g0, exp_seg); end
    total++;
    for (int k = 0; k < exp_dig.size() && q0 + k < obs_dig.size(); k++) begin
      if ({obs_dig[q0+k], obs_blk[q0+k]} !== {exp_dig[k], exp_blk[k]}) begin
        bad++;
        $display("FAIL rand_frame%0d got=%h/%h want=%h/%h", k, obs_dig[q0+k], obs_blk[q0+k], exp_dig[k], exp_blk[k]);
      end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_glitch();
    test_seq_order();
    test_seg_err();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
